// File: rtl/grid_run_scheduler.sv
// grid_run_scheduler: host-side sequencer for one grid generator instance.
// Resets the grid, launches an attempt with an 8-bit seed, waits for done,
// and retries with an LFSR-advanced seed on failure or timeout.
module grid_run_scheduler #(
    parameter int START_HOLD   = 30,
    parameter int MAX_CYCLES   = 22500,
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rq_start,
    input  logic [7:0] seed_init,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic [7:0] attempts,
    output logic [7:0] seed_used,
    output logic       grid_reset,
    output logic       grid_rq_start,
    output logic [7:0] grid_seed,
    input  logic       grid_done,
    input  logic       grid_success
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRST,
        ST_LAUNCH,
        ST_WAIT,
        ST_FINISH
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        done_prev;
    logic        done_edge;
    logic        timeout;
    logic [7:0]  seed_next;

    assign grid_seed = seed_used;

    // Done edge detect, WAIT timeout compare and next Galois LFSR seed.
    always_comb begin
        done_edge = grid_done & ~done_prev;
        timeout   = (cnt == 16'(MAX_CYCLES - 1));
        seed_next = {1'b0, seed_used[7:1]} ^ (seed_used[0] ? 8'hB8 : 8'h00);
    end

    // Sequencer FSM; every output is a register updated on state transitions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            done_prev     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            success       <= 1'b0;
            attempts      <= '0;
            seed_used     <= 8'h01;
            grid_reset    <= 1'b1;
            grid_rq_start <= 1'b0;
        end else begin
            done      <= 1'b0;
            done_prev <= grid_done;
            case (state)
                ST_IDLE: begin
                    grid_reset <= 1'b0;
                    busy       <= 1'b0;
                    if (rq_start) begin
                        seed_used  <= (seed_init == 8'h00) ? 8'h01 : seed_init;
                        attempts   <= 8'd1;
                        success    <= 1'b0;
                        busy       <= 1'b1;
                        grid_reset <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_GRST;
                    end
                end
                ST_GRST: begin
                    // A level left high by a previous attempt must not count as an edge.
                    done_prev <= 1'b0;
                    if (cnt == 16'd1) begin
                        grid_reset    <= 1'b0;
                        grid_rq_start <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_LAUNCH;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_LAUNCH: begin
                    if (cnt == 16'(START_HOLD - 1)) begin
                        grid_rq_start <= 1'b0;
                        cnt           <= '0;
                        state         <= ST_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (done_edge && grid_success) begin
                        success <= 1'b1;
                        done    <= 1'b1;
                        state   <= ST_FINISH;
                    end else if (done_edge || timeout) begin
                        if (attempts == 8'(MAX_ATTEMPTS)) begin
                            success <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_FINISH;
                        end else begin
                            attempts   <= attempts + 8'd1;
                            seed_used  <= seed_next;
                            grid_reset <= 1'b1;
                            cnt        <= '0;
                            state      <= ST_GRST;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy          <= 1'b0;
                    grid_reset    <= 1'b0;
                    grid_rq_start <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/grid_run_scheduler.md
# grid_run_scheduler

Host-side sequencer for one `grid` generator instance. On a host start request it resets the grid, launches a generation attempt with an 8-bit seed, and waits for `done`. Failed or timed-out attempts are retried with an LFSR-advanced seed until success or an attempt limit is reached. It sits between the top-level control and the `grid` instance and owns that instance's `reset`, `rq_start` and `seed` inputs.

## Interface
- `START_HOLD`, 30: cycles `grid_rq_start` is held high per launch (1..255).
- `MAX_CYCLES`, 22500: per-attempt timeout in cycles, counted from the first WAIT cycle (1..65535).
- `MAX_ATTEMPTS`, 8: attempts before giving up (1..255).
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rq_start`  in  1  host start request, sampled only in IDLE.
- `seed_init`  in  8  first-attempt seed, sampled with `rq_start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run ends.
- `success`  out  1  result of the last run, held until the next accepted start.
- `attempts`  out  8  attempts used in the current or last run, 1-based.
- `seed_used`  out  8  seed of the current or last attempt.
- `grid_reset`  out  1  active-high synchronous reset to `grid`.
- `grid_rq_start`  out  1  start request to `grid`.
- `grid_seed`  out  8  seed to `grid`; equals `seed_used`.
- `grid_done`  in  1  `grid` done.
- `grid_success`  in  1  `grid` success, valid with `grid_done`.

## Operation
- Reset values: state IDLE; `busy`, `done`, `success`, `grid_rq_start` = 0; `attempts` = 0; `seed_used` = `grid_seed` = 8'h01; `grid_reset` = 1 (holds the grid in reset while the scheduler is reset).
- States: IDLE, GRST, LAUNCH, WAIT, FINISH.
- IDLE: `grid_reset` = 0.
  - On `rq_start` = 1: latch the seed (`seed_init`, or 8'h01 when `seed_init` = 0, to avoid LFSR lock-up).
  - Set `attempts` = 1, clear `success`, go to GRST.
- GRST: `grid_reset` = 1 for exactly 2 cycles, then LAUNCH.
- LAUNCH: `grid_rq_start` = 1 for exactly `START_HOLD` cycles, then WAIT.
- WAIT: `grid_rq_start` = 0. A 16-bit cycle counter starts at 0 on entry.
  - On `grid_done` rising edge (previous sample 0, current 1) with `grid_success` = 1: `success` = 1, go to FINISH.
  - On `grid_done` rising edge with `grid_success` = 0, or when the counter reaches `MAX_CYCLES` - 1 with no edge: the attempt fails.
  - A done edge in the same cycle as the timeout takes priority over the timeout.
- Attempt failure:
  - If `attempts` = `MAX_ATTEMPTS`: `success` = 0, go to FINISH.
  - Otherwise: `attempts` += 1, seed advances one step of the Galois LFSR x^8+x^6+x^5+x^4+1 (shift right; if the shifted-out bit is 1, XOR with 8'hB8), go to GRST.
- FINISH: `done` = 1 for one cycle, then IDLE. `busy` drops in the same cycle IDLE is entered.
- `rq_start` outside IDLE is ignored; it is not queued.
- An edge detector on `grid_done` is used so a level held high from a previous run cannot complete a new attempt. The detector's previous-sample register is cleared in GRST.
- Reset asserted mid-run aborts immediately to reset values, with no `done` pulse.

## Timing
- Host `rq_start` high in IDLE at cycle 0 gives: `busy` = 1 from cycle 1; GRST in cycles 1-2; `grid_rq_start` high in cycles 3 .. 2+`START_HOLD`; WAIT from cycle 3+`START_HOLD`.
- Success latency: `done` pulses 1 cycle after the registered `grid_done` edge is seen in WAIT.
- Retry overhead: failure detection, then 2 GRST cycles, then `START_HOLD` LAUNCH cycles.
- A timeout fires on the `MAX_CYCLES`-th WAIT cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Pass on first try: `seed_init` = 8'h01; `grid` model asserts done+success 100 cycles into WAIT -> one `done` pulse, `success` = 1, `attempts` = 1, `seed_used` = 8'h01, `grid_rq_start` high exactly 30 cycles.
- Retry then pass: model fails the first attempt and passes the second -> `grid_reset` pulses twice (2 cycles each), second `grid_seed` = 8'hB8, `attempts` = 2, `success` = 1.
- Give up: model always fails, `MAX_ATTEMPTS` = 3 -> seeds 01, B8, 5C; `done` with `success` = 0 and `attempts` = 3.
- Timeout: `MAX_CYCLES` = 50, model never asserts done -> failure on the 50th WAIT cycle, retry begins; a done edge in that same cycle instead completes the attempt normally.
- Zero seed and stale done: `seed_init` = 0 -> seed 8'h01. `grid_done` held high from before the start -> no completion until a fresh rising edge.
- Reset mid-WAIT: `reset` = 0 -> all outputs return to reset values immediately, no `done`. After release, `rq_start` starts a clean run.
